desloca_serial: RTL and testbench
=================================

Name: desloca_serial

Overview:
- Multicycle shift unit for the datapath. It is the bit-serial counterpart of the single-cycle logic gates.
- Loads a LARGURA-bit word, then shifts it one bit per clock under a start/done handshake.
- The control FSM issues the operation and waits on pronto before writing saida back to the register bank.

Parameters:
LARGURA, 32, data width in bits
LARGURA_N, 5, width of the shift-amount field (must satisfy 2**LARGURA_N >= LARGURA)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
inicio  input  1  start strobe, sampled only in OCIOSO
operacao  input  3  000 nop, 001 load, 010 sll, 011 srl, 100 sra, 101 rotr, 110 rotl, 111 reserved
quantidade  input  LARGURA_N  shift amount N, captured on the inicio edge
entrada  input  LARGURA  load data
saida  output  LARGURA  shift register contents
ocupado  output  1  high while in DESLOCANDO
pronto  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high) forces: saida=0, contador=0, op_reg=000, state=OCIOSO, ocupado=0, pronto=0. Reset mid-shift aborts immediately; no pronto is issued.
- Clock and reset are the only asynchronous inputs; all other inputs are synchronous to clk.
- FSM states: OCIOSO, DESLOCANDO, PRONTO.
- OCIOSO, inicio=1, operacao=001: saida<=entrada on that edge; next state PRONTO.
- OCIOSO, inicio=1, shift/rotate op with N>=1: op_reg<=operacao, contador<=N, saida unchanged; next state DESLOCANDO.
- OCIOSO, inicio=1, shift/rotate op with N=0: saida unchanged; next state PRONTO.
- OCIOSO, inicio=1, operacao 000, 111, or a disabled rotate: ignored; stay OCIOSO, no pronto.
- OCIOSO, inicio=0: hold.
- DESLOCANDO, every edge: shift saida by one position per op_reg, contador<=contador-1. When contador==1, the edge performs the last shift and moves to PRONTO.
- PRONTO: pronto=1 for exactly one cycle; next state OCIOSO unconditionally. inicio in PRONTO is ignored.
- Latency: inicio sampled at edge t with N>=1 gives shifts at edges t+1..t+N and pronto high in the cycle following edge t+N. Load or N=0 gives pronto in the cycle following edge t.
- inicio, operacao, quantidade and entrada are don't-care outside OCIOSO. Changes during DESLOCANDO have no effect.
- Shift rules, one bit per edge:
  - sll inserts 0 at the LSB.
  - srl inserts 0 at the MSB.
  - sra replicates saida[LARGURA-1].
  - rotr moves bit 0 to the MSB.
  - rotl moves the MSB to bit 0.
- N is not clamped. N=31 on 32-bit data takes 31 shifts.
- Intermediate values are visible on saida during DESLOCANDO. Consumers must sample only when pronto=1.
- ocupado = (state==DESLOCANDO). ocupado and pronto are never high simultaneously.

Optional Feature:
- Macro: DESLOCA_ROTACAO_EN.
- Defined: operacao 101 (rotr) and 110 (rotl) are accepted and rotate as specified above.
- Undefined: 101 and 110 are treated like 111. They are ignored in OCIOSO, produce no pronto, leave saida unchanged, and no rotate logic is synthesized.

Test Plan:
- Reset, then load: assert reset async mid-cycle -> saida=0, ocupado=0, pronto=0 with no clk edge. Then inicio+001, entrada=32'h8000_00F0 -> saida=32'h8000_00F0 and pronto high for 1 cycle after that edge.
- sll: saida=32'h0000_0001, inicio+010, N=4 -> ocupado high 4 cycles, saida=32'h0000_0010, pronto 1 cycle, then OCIOSO.
- sra vs srl: saida=32'h8000_0000, N=31 -> sra gives 32'hFFFF_FFFF and srl gives 32'h0000_0001, each with pronto 32 cycles after the inicio edge.
- Boundaries:
  - N=0 sll on 32'h1234_5678 -> pronto next cycle, saida unchanged.
  - inicio+011 asserted during DESLOCANDO and during PRONTO -> ignored.
  - operacao=111 in OCIOSO -> no pronto.
- Reset mid-operation: sll N=10 and assert reset after 3 shifts -> saida=0, state OCIOSO, no pronto ever. A new load then works normally.
- Rotate:
  - With DESLOCA_ROTACAO_EN defined: rotr N=1 on 32'h0000_0001 -> 32'h8000_0000; rotl N=8 on 32'hFF00_0000 -> 32'h0000_00FF.
  - Without the macro: the same stimulus leaves saida unchanged and produces no pronto.

Source files
------------

// File: rtl/desloca_serial.sv
`default_nettype none
// ============================================================================
// Module   : desloca_serial
// Purpose  : Bit-serial shift/rotate unit. Loads a LARGURA-bit word and then
//            shifts it one position per clock under an inicio/pronto
//            handshake. ocupado is high while shifting, and pronto pulses for
//            one cycle when the result on saida is final.
// Options  : DESLOCA_ROTACAO_EN - when defined, rotr (101) and rotl (110) are
//            accepted. When undefined, they are ignored like the reserved
//            code and no rotate logic is built.
// Revision : 1.0 - initial release
// ============================================================================
module desloca_serial #(
   parameter int LARGURA   = 32,
   parameter int LARGURA_N = 5     // 2**LARGURA_N must be >= LARGURA
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inicio,
   input  logic [2:0]           operacao,
   input  logic [LARGURA_N-1:0] quantidade,
   input  logic [LARGURA-1:0]   entrada,
   output logic [LARGURA-1:0]   saida,
   output logic                 ocupado,
   output logic                 pronto
);

   // FSM encoding
   localparam logic [1:0] c_OCIOSO     = 2'd0;
   localparam logic [1:0] c_DESLOCANDO = 2'd1;
   localparam logic [1:0] c_PRONTO     = 2'd2;

   // Operation codes
   localparam logic [2:0] c_OP_LOAD = 3'b001;
   localparam logic [2:0] c_OP_SLL  = 3'b010;
   localparam logic [2:0] c_OP_SRL  = 3'b011;
   localparam logic [2:0] c_OP_SRA  = 3'b100;
`ifdef DESLOCA_ROTACAO_EN
   localparam logic [2:0] c_OP_ROTR = 3'b101;
   localparam logic [2:0] c_OP_ROTL = 3'b110;
`endif

   logic [1:0]           r_estado;
   logic [1:0]           w_prox_estado;
   logic [2:0]           r_op;
   logic [LARGURA_N-1:0] r_contador;
   logic [LARGURA-1:0]   r_saida;
   logic [LARGURA-1:0]   w_deslocado;
   logic                 w_op_desloc;
   logic                 w_n_zero;
   logic                 w_ultimo;

   assign w_n_zero = (quantidade == '0);
   assign w_ultimo = (r_contador == LARGURA_N'(1));
   assign saida    = r_saida;

   // Decode which codes are accepted as shift/rotate requests
   always_comb begin
      w_op_desloc = 1'b0;
      case (operacao)
         c_OP_SLL,
         c_OP_SRL,
         c_OP_SRA:  w_op_desloc = 1'b1;
`ifdef DESLOCA_ROTACAO_EN
         c_OP_ROTR,
         c_OP_ROTL: w_op_desloc = 1'b1;
`endif
         default:   w_op_desloc = 1'b0;
      endcase
   end

   // One-position shift of the current contents according to the latched op
   always_comb begin
      w_deslocado = r_saida;
      case (r_op)
         c_OP_SLL:  w_deslocado = {r_saida[LARGURA-2:0], 1'b0};
         c_OP_SRL:  w_deslocado = {1'b0, r_saida[LARGURA-1:1]};
         c_OP_SRA:  w_deslocado = {r_saida[LARGURA-1], r_saida[LARGURA-1:1]};
`ifdef DESLOCA_ROTACAO_EN
         c_OP_ROTR: w_deslocado = {r_saida[0], r_saida[LARGURA-1:1]};
         c_OP_ROTL: w_deslocado = {r_saida[LARGURA-2:0], r_saida[LARGURA-1]};
`endif
         default:   w_deslocado = r_saida;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_estado <= c_OCIOSO;
      end else begin
         r_estado <= w_prox_estado;
      end
   end

   // Next-state logic: requests are only honoured in OCIOSO
   always_comb begin
      w_prox_estado = r_estado;
      case (r_estado)
         c_OCIOSO: begin
            if (inicio) begin
               if (operacao == c_OP_LOAD) begin
                  w_prox_estado = c_PRONTO;
               end else if (w_op_desloc) begin
                  w_prox_estado = w_n_zero ? c_PRONTO : c_DESLOCANDO;
               end
            end
         end
         c_DESLOCANDO: begin
            if (w_ultimo) begin
               w_prox_estado = c_PRONTO;
            end
         end
         c_PRONTO: begin
            w_prox_estado = c_OCIOSO;
         end
         default: begin
            w_prox_estado = c_OCIOSO;
         end
      endcase
   end

   // Status outputs decoded straight from the state
   always_comb begin
      ocupado = (r_estado == c_DESLOCANDO);
      pronto  = (r_estado == c_PRONTO);
   end

   // Datapath: load, capture of op/count, and the per-cycle shift
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_saida    <= '0;
         r_contador <= '0;
         r_op       <= 3'b000;
      end else begin
         case (r_estado)
            c_OCIOSO: begin
               if (inicio) begin
                  if (operacao == c_OP_LOAD) begin
                     r_saida <= entrada;
                  end else if (w_op_desloc && !w_n_zero) begin
                     r_op       <= operacao;
                     r_contador <= quantidade;
                  end
               end
            end
            c_DESLOCANDO: begin
               r_saida    <= w_deslocado;
               r_contador <= r_contador - LARGURA_N'(1);
            end
            default: begin
               r_saida <= r_saida;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_desloca_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_desloca_serial
// Purpose  : Self-checking bench for desloca_serial. A transaction-level model
//            predicts result value, busy window and pronto cycle; a compare
//            process checks the outputs every cycle, and directed sequences
//            check hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_desloca_serial;

   localparam int LARGURA   = 32;
   localparam int LARGURA_N = 5;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SLL  = 3'b010;
   localparam logic [2:0] OP_SRL  = 3'b011;
   localparam logic [2:0] OP_SRA  = 3'b100;
   localparam logic [2:0] OP_ROTR = 3'b101;
   localparam logic [2:0] OP_ROTL = 3'b110;
   localparam logic [2:0] OP_RES  = 3'b111;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 inicio = 1'b0;
   logic [2:0]           operacao = 3'b000;
   logic [LARGURA_N-1:0] quantidade = '0;
   logic [LARGURA-1:0]   entrada = '0;
   logic [LARGURA-1:0]   saida;
   logic                 ocupado;
   logic                 pronto;

   int checks = 0;
   int errors = 0;

   // Model state: value, busy window (edge indices) and pronto edge
   int                 cyc = 0;
   int                 m_busy_from = 1;
   int                 m_busy_to = 0;
   int                 m_pronto_edge = -1;
   logic [LARGURA-1:0] m_val = '0;

   int lat;
   int cnt;

   desloca_serial #(.LARGURA(LARGURA), .LARGURA_N(LARGURA_N)) dut (
      .clk        (clk),
      .reset      (reset),
      .inicio     (inicio),
      .operacao   (operacao),
      .quantidade (quantidade),
      .entrada    (entrada),
      .saida      (saida),
      .ocupado    (ocupado),
      .pronto     (pronto)
   );

   always #5 clk = ~clk;

   function automatic bit op_valida(input logic [2:0] op);
`ifdef DESLOCA_ROTACAO_EN
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
             (op == OP_ROTR) || (op == OP_ROTL);
`else
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`endif
   endfunction

   // Whole-operation result using plain arithmetic
   function automatic logic [LARGURA-1:0] modelo(input logic [LARGURA-1:0] v,
                                                  input logic [2:0] op, input int n);
      logic [2*LARGURA-1:0] d;
      case (op)
         OP_SLL:  return v << n;
         OP_SRL:  return v >> n;
         OP_SRA:  return LARGURA'($signed(v) >>> n);
         OP_ROTR: begin d = {v, v} >> n; return d[LARGURA-1:0]; end
         OP_ROTL: begin d = {v, v} << n; return d[2*LARGURA-1:LARGURA]; end
         default: return v;
      endcase
   endfunction

   function automatic bit m_busy();
      return (cyc >= m_busy_from) && (cyc < m_busy_to);
   endfunction

   task automatic check_val(input string nome, input logic [LARGURA-1:0] act,
                            input logic [LARGURA-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nome, act, exp, $time);
      end
   endtask

   task automatic check_int(input string nome, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string nome, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nome, act, exp, $time);
      end
   endtask

   // Model update: a request counts only when the model says the unit is idle
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_val         = '0;
         m_busy_from   = 1;
         m_busy_to     = 0;
         m_pronto_edge = -1;
      end else begin
         bit idle;
         idle = !m_busy() && (cyc != m_pronto_edge);
         cyc  = cyc + 1;
         if (idle && inicio) begin
            if (operacao == OP_LOAD) begin
               m_val         = entrada;
               m_pronto_edge = cyc;
            end else if (op_valida(operacao)) begin
               m_val         = modelo(m_val, operacao, int'(quantidade));
               m_busy_from   = cyc;
               m_busy_to     = cyc + int'(quantidade);
               m_pronto_edge = cyc + int'(quantidade);
            end
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (!reset) begin
         check_bit("ocupado", ocupado, m_busy());
         check_bit("pronto", pronto, cyc == m_pronto_edge);
         if (!m_busy()) check_val("saida estavel", saida, m_val);
      end
   end

   // Issue one request, wait for pronto (bounded), check latency and result
   task automatic executa(input string nome, input logic [2:0] op, input int n,
                          input logic [LARGURA-1:0] dado, input bit espera_pronto,
                          input logic [LARGURA-1:0] esperado);
      int l;
      int ocu;
      @(negedge clk);
      inicio     = 1'b1;
      operacao   = op;
      quantidade = LARGURA_N'(n);
      entrada    = dado;
      @(posedge clk);
      #1;
      inicio     = 1'b0;
      operacao   = OP_NOP;
      quantidade = LARGURA_N'(n + 7);
      entrada    = ~dado;
      l   = -1;
      ocu = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (ocupado === 1'b1) ocu++;
         if (pronto === 1'b1) begin
            l = j;
            break;
         end
      end
      if (espera_pronto) begin
         check_int({nome, " latencia"}, l, (op == OP_LOAD) ? 0 : n);
         check_int({nome, " ciclos ocupado"}, ocu, (op == OP_LOAD) ? 0 : n);
      end else begin
         check_int({nome, " sem pronto"}, l, -1);
         check_int({nome, " sem ocupado"}, ocu, 0);
      end
      check_val({nome, " saida"}, saida, esperado);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;

      // Async reset with no clock edge
      executa("carga AAAA5555", OP_LOAD, 0, 32'hAAAA_5555, 1'b1, 32'hAAAA_5555);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check_val("reset async saida", saida, 32'h0);
      check_bit("reset async ocupado", ocupado, 1'b0);
      check_bit("reset async pronto", pronto, 1'b0);
      @(negedge clk);
      #2 reset = 1'b0;

      executa("carga 800000F0", OP_LOAD, 0, 32'h8000_00F0, 1'b1, 32'h8000_00F0);

      executa("carga 1", OP_LOAD, 0, 32'h0000_0001, 1'b1, 32'h0000_0001);
      executa("sll 4", OP_SLL, 4, 32'h0, 1'b1, 32'h0000_0010);

      executa("carga 80000000 a", OP_LOAD, 0, 32'h8000_0000, 1'b1, 32'h8000_0000);
      executa("sra 31", OP_SRA, 31, 32'h0, 1'b1, 32'hFFFF_FFFF);
      executa("carga 80000000 b", OP_LOAD, 0, 32'h8000_0000, 1'b1, 32'h8000_0000);
      executa("srl 31", OP_SRL, 31, 32'h0, 1'b1, 32'h0000_0001);

      executa("carga 12345678", OP_LOAD, 0, 32'h1234_5678, 1'b1, 32'h1234_5678);
      executa("sll 0", OP_SLL, 0, 32'h0, 1'b1, 32'h1234_5678);

      executa("reservado 111", OP_RES, 3, 32'h0, 1'b0, 32'h1234_5678);
      executa("nop 000", OP_NOP, 3, 32'h0, 1'b0, 32'h1234_5678);

      // inicio+srl held high through DESLOCANDO and PRONTO must be ignored
      executa("carga F0", OP_LOAD, 0, 32'h0000_00F0, 1'b1, 32'h0000_00F0);
      @(negedge clk);
      inicio     = 1'b1;
      operacao   = OP_SLL;
      quantidade = 5'd3;
      @(posedge clk);
      #1;
      operacao   = OP_SRL;
      quantidade = 5'd5;
      entrada    = 32'hDEAD_BEEF;
      lat = -1;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (pronto === 1'b1) begin
            lat = j;
            break;
         end
      end
      @(negedge clk);
      inicio   = 1'b0;
      operacao = OP_NOP;
      check_int("sll 3 com ruido latencia", lat, 3);
      check_val("sll 3 com ruido saida", saida, 32'h0000_0780);
      cnt = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (pronto === 1'b1 || ocupado === 1'b1) cnt++;
      end
      check_int("inicio ignorado fora de OCIOSO", cnt, 0);
      check_val("saida apos ruido", saida, 32'h0000_0780);

      // Reset in the middle of a shift
      executa("carga 1 b", OP_LOAD, 0, 32'h0000_0001, 1'b1, 32'h0000_0001);
      @(negedge clk);
      inicio     = 1'b1;
      operacao   = OP_SLL;
      quantidade = 5'd10;
      @(posedge clk);
      #1;
      inicio   = 1'b0;
      operacao = OP_NOP;
      repeat (4) @(negedge clk);
      check_val("sll 10 apos 3 passos", saida, 32'h0000_0008);
      check_bit("sll 10 ocupado", ocupado, 1'b1);
      #2 reset = 1'b1;
      #1;
      check_val("reset no meio saida", saida, 32'h0);
      check_bit("reset no meio ocupado", ocupado, 1'b0);
      @(negedge clk);
      #2 reset = 1'b0;
      cnt = 0;
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         if (pronto === 1'b1 || ocupado === 1'b1) cnt++;
      end
      check_int("sem pronto apos reset", cnt, 0);
      executa("carga 5 apos reset", OP_LOAD, 0, 32'h0000_0005, 1'b1, 32'h0000_0005);

      // Rotates
      executa("carga 1 rot", OP_LOAD, 0, 32'h0000_0001, 1'b1, 32'h0000_0001);
`ifdef DESLOCA_ROTACAO_EN
      executa("rotr 1", OP_ROTR, 1, 32'h0, 1'b1, 32'h8000_0000);
`else
      executa("rotr 1 desabilitado", OP_ROTR, 1, 32'h0, 1'b0, 32'h0000_0001);
`endif
      executa("carga FF000000", OP_LOAD, 0, 32'hFF00_0000, 1'b1, 32'hFF00_0000);
`ifdef DESLOCA_ROTACAO_EN
      executa("rotl 8", OP_ROTL, 8, 32'h0, 1'b1, 32'h0000_00FF);
`else
      executa("rotl 8 desabilitado", OP_ROTL, 8, 32'h0, 1'b0, 32'hFF00_0000);
`endif

      // Mixed requests checked against the model
      for (int i = 0; i < 12; i++) begin
         logic [2:0]         op;
         int                 n;
         logic [LARGURA-1:0] d;
         logic [LARGURA-1:0] exp;
         bit                 aceita;
         op = 3'($urandom_range(0, 7));
         n  = $urandom_range(0, 31);
         d  = $urandom;
         if (i < 3) op = OP_LOAD;
         aceita = (op == OP_LOAD) || op_valida(op);
         if (op == OP_LOAD)  exp = d;
         else if (aceita)    exp = modelo(m_val, op, n);
         else                exp = m_val;
         executa($sformatf("misto %0d op %b n %0d", i, op, n), op, n, d, aceita, exp);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
